mem_access_ctrl: RTL and testbench

- Initiator side of the 16-bit data-memory interface. Sits in the processor MEM stage between the pipeline and the data memory.
- Accepts one load/store request at a time, either narrow (16-bit) or wide (32-bit, e.g. PC push/pop).
- Splits wide requests into two sequential 16-bit memory accesses and drives registered, glitch-free address/data/strobe signals to the memory.
- Returns assembled read data and a one-cycle Done pulse, or a Fault for out-of-range addresses.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_addr_check.sv | 16 +
 rtl/mem_access_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory interface: widths, memory depth,
// controller state encoding and the latched request payload.
package mem_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MEM_DEPTH = 2048;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic                  write;
        logic                  wide;
        logic [ADDR_W-1:0]     addr;
        logic [2*DATA_W-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational range check for a one- or two-word access starting at addr.
// Compares against depth-1 for wide accesses so addr+1 is never formed.
module mem_addr_check
    import mem_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic              wide,
    output logic              fault_c
);

    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);

    assign fault_c = (addr >= DEPTH) || (wide && (addr >= LAST));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator: accepts one narrow/wide load or store, issues one or two
// registered 16-bit memory accesses, and returns read data with a Done pulse.
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                req_write,
    input  logic                req_wide,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                ready,
    output logic                done,
    output logic                fault,
    output logic [2*DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_data_in,
    output logic                mem_read,
    output logic                mem_write,
    input  logic [DATA_W-1:0]   mem_data_out
);

    mem_state_e          state, state_nxt;
    mem_req_t            req_q, req_q_nxt;
    logic                ready_nxt, done_nxt, fault_nxt;
    logic [2*DATA_W-1:0] rd_data_nxt;
    logic [ADDR_W-1:0]   mem_address_nxt;
    logic [DATA_W-1:0]   mem_data_in_nxt;
    logic                mem_read_nxt, mem_write_nxt;
    logic                addr_fault_c;

    mem_addr_check u_addr_check (
        .addr    (req_addr),
        .wide    (req_wide),
        .fault_c (addr_fault_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            fault       <= 1'b0;
            rd_data     <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_q       <= req_q_nxt;
            ready       <= ready_nxt;
            done        <= done_nxt;
            fault       <= fault_nxt;
            rd_data     <= rd_data_nxt;
            mem_address <= mem_address_nxt;
            mem_data_in <= mem_data_in_nxt;
            mem_read    <= mem_read_nxt;
            mem_write   <= mem_write_nxt;
        end
    end

    // Outputs are computed one state ahead so the memory sees clean flop outputs.
    always_comb begin
        state_nxt       = state;
        req_q_nxt       = req_q;
        done_nxt        = 1'b0;
        fault_nxt       = 1'b0;
        rd_data_nxt     = rd_data;
        mem_address_nxt = mem_address;
        mem_data_in_nxt = mem_data_in;
        mem_read_nxt    = 1'b0;
        mem_write_nxt   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    req_q_nxt.write = req_write;
                    req_q_nxt.wide  = req_wide;
                    req_q_nxt.addr  = req_addr;
                    req_q_nxt.wdata = req_wdata;
                    if (addr_fault_c) begin
                        state_nxt = ST_RESP;
                        done_nxt  = 1'b1;
                        fault_nxt = 1'b1;
                    end else begin
                        state_nxt       = ST_ACC0;
                        mem_address_nxt = req_addr;
                        mem_data_in_nxt = req_wide ? req_wdata[2*DATA_W-1:DATA_W]
                                                   : req_wdata[DATA_W-1:0];
                        mem_read_nxt    = !req_write;
                        mem_write_nxt   = req_write;
                    end
                end
            end
            ST_ACC0: begin
                if (!req_q.write) begin
                    rd_data_nxt = req_q.wide ? {mem_data_out, rd_data[DATA_W-1:0]}
                                             : {{DATA_W{1'b0}}, mem_data_out};
                end
                if (req_q.wide) begin
                    state_nxt       = ST_ACC1;
                    mem_address_nxt = req_q.addr + ADDR_W'(1);
                    mem_data_in_nxt = req_q.wdata[DATA_W-1:0];
                    mem_read_nxt    = !req_q.write;
                    mem_write_nxt   = req_q.write;
                end else begin
                    state_nxt = ST_RESP;
                    done_nxt  = 1'b1;
                end
            end
            ST_ACC1: begin
                if (!req_q.write) begin
                    rd_data_nxt = {rd_data[2*DATA_W-1:DATA_W], mem_data_out};
                end
                state_nxt = ST_RESP;
                done_nxt  = 1'b1;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        ready_nxt = (state_nxt == ST_IDLE);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural 16-bit data memory
// whose unwritten words read as 16'h0F0F.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req, req_write, req_wide;
    logic [31:0] req_addr, req_wdata;
    logic        ready, done, fault;
    logic [31:0] rd_data, mem_address;
    logic [15:0] mem_data_in, mem_data_out;
    logic        mem_read, mem_write;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_write    (req_write),
        .req_wide     (req_wide),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ready        (ready),
        .done         (done),
        .fault        (fault),
        .rd_data      (rd_data),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: synchronous write, combinational read.
    bit [15:0] mem   [2048];
    bit        wrote [2048];

    always @(posedge clk) begin
        if (mem_write && mem_address < 32'd2048) begin
            mem[mem_address[10:0]]   <= mem_data_in;
            wrote[mem_address[10:0]] <= 1'b1;
        end
    end

    function automatic logic [15:0] rd_word(input logic [31:0] a);
        if (a >= 32'd2048) return 16'h0000;
        return wrote[a[10:0]] ? mem[a[10:0]] : 16'h0F0F;
    endfunction

    always_comb mem_data_out = rd_word(mem_address);

    typedef struct {
        logic        flt;
        logic [31:0] rd;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [15:0] data;
    } acc_t;

    resp_t sb_q[$];
    acc_t  st_q[$];
    int    acc_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int exp_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: response scoreboard, strobe trace and accept timestamps.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read || mem_write) begin
                chk("strobe_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
                if (st_q.size() == 0) begin
                    chk("unexpected_strobe", mem_address, 32'hFFFF_FFFF);
                end else begin
                    acc_t e;
                    e = st_q.pop_front();
                    chk("strobe_addr", mem_address, e.addr);
                    chk("strobe_write", {31'd0, mem_write}, {31'd0, e.wr});
                    if (e.wr) chk("strobe_data", {16'd0, mem_data_in}, {16'd0, e.data});
                end
            end
            if (done) begin
                done_cnt++;
                if (sb_q.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    resp_t r;
                    int    a;
                    r = sb_q.pop_front();
                    a = acc_q.pop_front();
                    chk("fault", {31'd0, fault}, {31'd0, r.flt});
                    chk("rd_data", rd_data, r.rd);
                    chk("latency", 32'(cyc - a + 1), 32'(r.lat));
                end
            end
            if (req && ready) acc_q.push_back(cyc + 1);
        end
    end

    // Issue one request; leaves req high so back-to-back calls model a held request.
    task automatic do_req(input logic wr, input logic wd, input logic [31:0] a,
                          input logic [31:0] wdat, input logic flt,
                          input logic [31:0] exp_rd, input int lat);
        resp_t r;
        bit    ok;
        r.flt = flt; r.rd = exp_rd; r.lat = lat;
        sb_q.push_back(r);
        exp_cnt++;
        if (!flt) begin
            acc_t e;
            e.addr = a; e.wr = wr; e.data = wd ? wdat[31:16] : wdat[15:0];
            st_q.push_back(e);
            if (wd) begin
                e.addr = a + 32'd1; e.data = wdat[15:0];
                st_q.push_back(e);
            end
        end
        req = 1'b1; req_write = wr; req_wide = wd; req_addr = a; req_wdata = wdat;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_mem_address"}, mem_address, 32'd0);
        chk({tag, "_mem_data_in"}, {16'd0, mem_data_in}, 32'd0);
        chk({tag, "_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; req_write = 1'b0; req_wide = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Narrow store / load round trip
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0000_BEEF, 1'b0, 32'h0000_0000, 2);
        idle(2);
        do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0000_BEEF, 2);
        idle(2);

        // Wide store / load at the top two words
        do_req(1'b1, 1'b1, 32'h0000_07FE, 32'h1234_5678, 1'b0, 32'h0000_BEEF, 3);
        idle(2);
        chk("mem_7fe", {16'd0, rd_word(32'h7FE)}, 32'h0000_1234);
        chk("mem_7ff", {16'd0, rd_word(32'h7FF)}, 32'h0000_5678);
        do_req(1'b0, 1'b1, 32'h0000_07FE, 32'h0000_0000, 1'b0, 32'h1234_5678, 3);
        idle(2);

        // Range faults, including the no-wrap top address
        do_req(1'b0, 1'b1, 32'h0000_07FF, 32'h0000_0000, 1'b1, 32'h1234_5678, 1);
        idle(2);
        do_req(1'b1, 1'b0, 32'h0000_0800, 32'h0000_DEAD, 1'b1, 32'h1234_5678, 1);
        idle(2);
        do_req(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h1234_5678, 1);
        idle(2);

        // Preloaded word, then a fault must leave rd_data alone
        do_req(1'b0, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h0000_0F0F, 2);
        idle(2);
        do_req(1'b0, 1'b1, 32'h0000_0800, 32'h0000_0000, 1'b1, 32'h0000_0F0F, 1);
        idle(2);

        // Request held high across a mixed back-to-back sequence
        do_req(1'b1, 1'b0, 32'h0000_0030, 32'h0000_1111, 1'b0, 32'h0000_0F0F, 2);
        do_req(1'b0, 1'b1, 32'h0000_002F, 32'h0000_0000, 1'b0, 32'h0F0F_1111, 3);
        do_req(1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 32'h0F0F_1111, 3);
        do_req(1'b0, 1'b0, 32'h0000_0041, 32'h0000_0000, 1'b0, 32'h0000_F00D, 2);
        do_req(1'b0, 1'b0, 32'h0000_0900, 32'h0000_0000, 1'b1, 32'h0000_F00D, 1);
        do_req(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 3);
        idle(4);

        // Reset during the second beat of a wide store
        begin
            acc_t e;
            e.addr = 32'h100; e.wr = 1'b1; e.data = 16'hAABB;
            st_q.push_back(e);
        end
        req = 1'b1; req_write = 1'b1; req_wide = 1'b1;
        req_addr = 32'h0000_0100; req_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        chk("abort_ready_before", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("acc1_address", mem_address, 32'h0000_0101);
        chk("acc1_write", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        acc_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("post_abort");
        chk("abort_mem_100", {16'd0, rd_word(32'h100)}, 32'h0000_AABB);
        chk("abort_mem_101", {16'd0, rd_word(32'h101)}, 32'h0000_0F0F);

        do_req(1'b0, 1'b1, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hAABB_0F0F, 3);
        idle(6);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("strobes_consumed", 32'(st_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
